fwd_scoreboard: RTL and testbench
=================================

Name: fwd_scoreboard

Overview:
- Parametrised successor to the pipeline forwarding unit.
- Keeps its own registered shadow of the EX stage and of DEPTH later pipeline stages: valid, Rd, RegWrite, MemRead, and the EX-stage source register numbers.
- From that state it generates per-source forwarding selects for the instruction in EX, plus a load-use stall request for the instruction in ID.
- Sits beside the ID/EX..MEM/WB pipeline registers; the datapath operand muxes consume fwd_sel, and the ID-stage hold logic consumes load_use_stall.

Parameters:
- REG_W, 5, register-number width.
- NUM_SRC, 2, source operands per instruction (Rn, Rm, ...).
- DEPTH, 2, forwardable stages after EX (1 = EX/MEM, 2 = MEM/WB, ...); must be ≥1.
- ZERO_REG, 31, register that is never written or forwarded (XZR).
- SEL_W, $clog2(DEPTH+1), width of each select field.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- advance  in  1  pipeline moves this edge; 0 = whole scoreboard holds.
- issue_valid  in  1  ID holds a real instruction.
- issue_rd  in  REG_W  ID destination register.
- issue_regwrite  in  1  ID instruction writes Rd.
- issue_memread  in  1  ID instruction is a load.
- id_src  in  NUM_SRC*REG_W  ID source registers; source s at [s*REG_W +: REG_W].
- flush  in  1  squash the ID instruction instead of issuing it.
- fwd_sel  out  NUM_SRC*SEL_W  per EX source, at [s*SEL_W +: SEL_W]: 0 = register file, k = stage k.
- load_use_stall  out  1  ID must hold; a bubble is inserted into EX.

Behaviour:
- Entry state: entries 0..DEPTH, each holding {v, rd, rw, mr}; entry 0 = EX. ex_src[NUM_SRC] is registered alongside entry 0.
- Clock edge with reset=1: all v, rw, mr, rd and ex_src clear to 0. This overrides advance and flush and applies mid-operation.
- Clock edge with reset=0 and advance=1:
  - entry k <= entry k-1 for k = 1..DEPTH; entry DEPTH's old contents drop off.
  - entry 0 <= {issue_valid & ~flush & ~load_use_stall, issue_rd, issue_regwrite, issue_memread}; ex_src <= id_src.
  - When v is 0 on entry, rw and mr are also written 0 (bubble).
- Clock edge with reset=0 and advance=0: every entry and ex_src holds. flush is ignored.
- fwd_sel is combinational from registered state, valid in the same cycle; there is no extra latency.
  - For each source s independently: if entry 0 has v=1, sel_s = the smallest k in 1..DEPTH with v_k & rw_k & (rd_k == ex_src[s]) & (rd_k != ZERO_REG). Otherwise sel_s = 0.
  - The nearest producer wins when several entries match.
  - A match on one source never suppresses or alters another source's select. Every output bit is assigned on every path; no latches.
- load_use_stall is combinational: issue_valid & v_0 & mr_0 & rw_0 & (rd_0 != ZERO_REG) & (any s: id_src[s] == rd_0).
  - It is not gated by advance.
  - It is not gated by flush; flush already forces a bubble.
- Invariant (bench asserts): no fwd_sel field ever selects an entry k=1 that has mr=1. Load-use hazards are converted into a bubble before they can occur.
- A source equal to ZERO_REG always yields sel 0, even if some entry's rd equals ZERO_REG with rw=1.

Test Plan:
1. Reset: assert reset 2 cycles with advance=1 and random inputs -> fwd_sel=0 and load_use_stall=0 throughout and on the cycle after release.
2. Nearest-producer priority, DEPTH=2:
   - Issue ADD X3 (rw=1), then SUB X3 (rw=1), then a consumer with src0=X3, all with advance=1 -> consumer in EX shows fwd_sel[src0]=1.
   - Insert one bubble before the consumer instead -> sel=2.
3. Independent sources: entry 1 writes X1, entry 2 writes X2; EX instruction has src0=X1, src1=X2 -> fwd_sel = {2,1}, i.e. sel0=1 and sel1=2 simultaneously.
4. Load-use:
   - LDUR X2 in EX, ID src0=X2, issue_valid=1 -> load_use_stall=1.
   - After the advance: entry 0 is a bubble and stall=0.
   - Next advance, consumer issued -> fwd_sel[src0]=2.
5. Zero register: producer with rd=X31, rw=1 in entry 1; consumer src0=X31 -> sel0=0. A load to X31 never raises the stall.
6. Hold, flush and reset mid-flight:
   - advance=0 for 3 cycles -> fwd_sel constant.
   - flush=1 with advance=1 -> entry 0 becomes a bubble and all fwd_sel read 0.
   - reset asserted with entries full -> all state clears on the next edge.

Source files
------------

// File: rtl/fwd_scoreboard_if.sv
`default_nettype none
// ============================================================================
//  Module   : fwd_scoreboard_if
//  Brief    : ID-stage issue bundle and EX forwarding/stall results.
//  Revision : 1.0
// ============================================================================
interface fwd_scoreboard_if #(
    parameter int REG_W   = 5,
    parameter int NUM_SRC = 2,
    parameter int DEPTH   = 2,
    parameter int SEL_W   = $clog2(DEPTH + 1)
);
    logic                       advance;
    logic                       issue_valid;
    logic [REG_W-1:0]           issue_rd;
    logic                       issue_regwrite;
    logic                       issue_memread;
    logic [NUM_SRC*REG_W-1:0]   id_src;
    logic                       flush;
    logic [NUM_SRC*SEL_W-1:0]   fwd_sel;
    logic                       load_use_stall;

    modport master (
        output advance, issue_valid, issue_rd, issue_regwrite, issue_memread,
               id_src, flush,
        input  fwd_sel, load_use_stall
    );

    modport slave (
        input  advance, issue_valid, issue_rd, issue_regwrite, issue_memread,
               id_src, flush,
        output fwd_sel, load_use_stall
    );
endinterface
`default_nettype wire

// File: rtl/fwd_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : fwd_scoreboard
//  Brief    : Shadow of EX + DEPTH later stages; per-source forwarding selects
//             for EX and a load-use stall request for ID.
//  Revision : 1.0
// ============================================================================
module fwd_scoreboard #(
    parameter int REG_W    = 5,
    parameter int NUM_SRC  = 2,
    parameter int DEPTH    = 2,
    parameter int ZERO_REG = 31,
    parameter int SEL_W    = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               reset,
    fwd_scoreboard_if.slave    bus
);
    localparam logic [REG_W-1:0] c_zero_reg = REG_W'(ZERO_REG);

    // Entry 0 is EX; entry k is k stages past EX.
    logic [DEPTH:0]                  r_v;
    logic [DEPTH:0]                  r_rw;
    logic [DEPTH:0]                  r_mr;
    logic [DEPTH:0][REG_W-1:0]       r_rd;
    logic [NUM_SRC-1:0][REG_W-1:0]   r_ex_src;

    logic w_issue_ok;
    logic w_src_hit;
    logic w_stall;

    assign w_issue_ok = bus.issue_valid & ~bus.flush & ~w_stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_v      <= '0;
            r_rw     <= '0;
            r_mr     <= '0;
            r_rd     <= '0;
            r_ex_src <= '0;
        end else if (bus.advance) begin
            for (int k = DEPTH; k >= 1; k--) begin
                r_v[k]  <= r_v[k-1];
                r_rw[k] <= r_rw[k-1];
                r_mr[k] <= r_mr[k-1];
                r_rd[k] <= r_rd[k-1];
            end
            r_v[0]   <= w_issue_ok;
            r_rd[0]  <= bus.issue_rd;
            r_rw[0]  <= w_issue_ok & bus.issue_regwrite;
            r_mr[0]  <= w_issue_ok & bus.issue_memread;
            r_ex_src <= bus.id_src;
        end
    end

    always_comb begin
        w_src_hit = 1'b0;
        for (int s = 0; s < NUM_SRC; s++) begin
            if (bus.id_src[s*REG_W +: REG_W] == r_rd[0]) begin
                w_src_hit = 1'b1;
            end
        end
    end

    assign w_stall = bus.issue_valid & r_v[0] & r_mr[0] & r_rw[0]
                   & (r_rd[0] != c_zero_reg) & w_src_hit;
    assign bus.load_use_stall = w_stall;

    generate
        for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
            logic [SEL_W-1:0] w_sel;

            // Scan oldest to youngest so the nearest matching producer wins.
            always_comb begin
                w_sel = '0;
                if (r_v[0]) begin
                    for (int k = DEPTH; k >= 1; k--) begin
                        if (r_v[k] && r_rw[k] && (r_rd[k] == r_ex_src[s])
                            && (r_rd[k] != c_zero_reg)) begin
                            w_sel = SEL_W'(k);
                        end
                    end
                end
            end

            assign bus.fwd_sel[s*SEL_W +: SEL_W] = w_sel;
        end
    endgenerate
endmodule
`default_nettype wire

// File: tb/tb_fwd_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fwd_scoreboard
//  Brief    : Directed bench for fwd_scoreboard (REG_W=5, NUM_SRC=2, DEPTH=2).
//  Revision : 1.0
// ============================================================================
module tb_fwd_scoreboard;
    logic clk = 1'b0;
    logic reset;
    int   n_assert = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    fwd_scoreboard_if #(.REG_W(5), .NUM_SRC(2), .DEPTH(2)) bus ();

    fwd_scoreboard #(.REG_W(5), .NUM_SRC(2), .DEPTH(2), .ZERO_REG(31)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Tracks whether the entry one stage past EX holds a load.
    logic       m_v0  = 1'b0;
    logic       m_rw0 = 1'b0;
    logic       m_mr0 = 1'b0;
    logic       m_mr1 = 1'b0;
    logic [4:0] m_rd0 = 5'd0;
    logic       m_stall;

    assign m_stall = bus.issue_valid & m_v0 & m_mr0 & m_rw0 & (m_rd0 != 5'd31)
                   & ((bus.id_src[4:0] == m_rd0) | (bus.id_src[9:5] == m_rd0));

    always @(posedge clk) begin
        if (reset) begin
            m_v0 <= 1'b0; m_rw0 <= 1'b0; m_mr0 <= 1'b0; m_mr1 <= 1'b0; m_rd0 <= 5'd0;
        end else if (bus.advance) begin
            m_mr1 <= m_mr0;
            m_v0  <= bus.issue_valid & ~bus.flush & ~m_stall;
            m_rw0 <= bus.issue_valid & ~bus.flush & ~m_stall & bus.issue_regwrite;
            m_mr0 <= bus.issue_valid & ~bus.flush & ~m_stall & bus.issue_memread;
            m_rd0 <= bus.issue_rd;
        end
    end

    always @(negedge clk) begin
        if (!reset && m_mr1) begin
            n_assert++;
            assert ((bus.fwd_sel[1:0] != 2'd1) && (bus.fwd_sel[3:2] != 2'd1)) else begin
                n_fail++;
                $error("FAIL no_fwd_from_load observed=%b expected=no field equal to 1", bus.fwd_sel);
            end
        end
    end

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] rd, input logic rw,
                         input logic mr, input logic [4:0] s0, input logic [4:0] s1);
        bus.issue_valid    = v;
        bus.issue_rd       = rd;
        bus.issue_regwrite = rw;
        bus.issue_memread  = mr;
        bus.id_src         = {s1, s0};
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        drive(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0);
        repeat (3) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset       = 1'b1;
        bus.advance = 1'b1;
        bus.flush   = 1'b0;
        drive(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0);

        // Reset with random ID-side activity.
        repeat (2) begin
            tick();
            drive(1'($urandom), 5'($urandom), 1'($urandom), 1'($urandom),
                  5'($urandom), 5'($urandom));
            bus.flush = 1'($urandom);
            #1;
            chk("reset_fwd_sel", bus.fwd_sel, 4'b0000);
            chk("reset_stall", {3'b000, bus.load_use_stall}, 4'b0000);
        end
        reset     = 1'b0;
        bus.flush = 1'b0;
        drive(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0);
        tick();
        chk("release_fwd_sel", bus.fwd_sel, 4'b0000);
        chk("release_stall", {3'b000, bus.load_use_stall}, 4'b0000);

        // Nearest producer: ADD X3, SUB X3, consumer src0=X3.
        drive(1'b1, 5'd3, 1'b1, 1'b0, 5'd0, 5'd0); tick();
        drive(1'b1, 5'd3, 1'b1, 1'b0, 5'd0, 5'd0); tick();
        drive(1'b1, 5'd9, 1'b1, 1'b0, 5'd3, 5'd4); tick();
        chk("nearest_sel1", bus.fwd_sel, 4'b0001);

        // Bubble between producer and consumer.
        drain();
        drive(1'b1, 5'd3, 1'b1, 1'b0, 5'd0, 5'd0); tick();
        drive(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0); tick();
        drive(1'b1, 5'd9, 1'b1, 1'b0, 5'd3, 5'd4); tick();
        chk("bubble_sel2", bus.fwd_sel, 4'b0010);

        // Independent sources: X2 in stage 2, X1 in stage 1.
        drain();
        drive(1'b1, 5'd2, 1'b1, 1'b0, 5'd0, 5'd0); tick();
        drive(1'b1, 5'd1, 1'b1, 1'b0, 5'd0, 5'd0); tick();
        drive(1'b1, 5'd9, 1'b1, 1'b0, 5'd1, 5'd2); tick();
        chk("indep_sel_2_1", bus.fwd_sel, 4'b1001);

        // Load-use: LDUR X2 in EX, consumer in ID.
        drain();
        drive(1'b1, 5'd2, 1'b1, 1'b1, 5'd0, 5'd0); tick();
        drive(1'b1, 5'd5, 1'b1, 1'b0, 5'd2, 5'd0); #1;
        chk("lu_stall_high", {3'b000, bus.load_use_stall}, 4'b0001);
        tick();
        chk("lu_bubble_stall_low", {3'b000, bus.load_use_stall}, 4'b0000);
        chk("lu_bubble_fwd_zero", bus.fwd_sel, 4'b0000);
        tick();
        chk("lu_consumer_sel2", bus.fwd_sel, 4'b0010);

        // Zero register never forwards and never stalls.
        drain();
        drive(1'b1, 5'd31, 1'b1, 1'b0, 5'd0, 5'd0); tick();
        drive(1'b1, 5'd8, 1'b1, 1'b0, 5'd31, 5'd31); tick();
        chk("xzr_no_fwd", bus.fwd_sel, 4'b0000);
        drive(1'b1, 5'd31, 1'b1, 1'b1, 5'd0, 5'd0); tick();
        drive(1'b1, 5'd9, 1'b1, 1'b0, 5'd31, 5'd31); #1;
        chk("xzr_no_stall", {3'b000, bus.load_use_stall}, 4'b0000);

        // Hold for three cycles while ID inputs change.
        drain();
        drive(1'b1, 5'd3, 1'b1, 1'b0, 5'd0, 5'd0); tick();
        drive(1'b1, 5'd4, 1'b1, 1'b0, 5'd0, 5'd0); tick();
        drive(1'b1, 5'd9, 1'b1, 1'b0, 5'd4, 5'd3); tick();
        chk("hold_pre", bus.fwd_sel, 4'b1001);
        bus.advance = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 5'(10 + i), 1'b1, 1'b0, 5'd9, 5'd4);
            bus.flush = 1'b1;
            tick();
            chk("hold_fwd_const", bus.fwd_sel, 4'b1001);
        end

        // Flush on advance squashes the issuing instruction.
        bus.advance = 1'b1;
        drive(1'b1, 5'd7, 1'b1, 1'b0, 5'd9, 5'd4);
        bus.flush = 1'b1;
        tick();
        chk("flush_fwd_zero", bus.fwd_sel, 4'b0000);
        bus.flush = 1'b0;

        // Reset mid-flight with live state and an active stall.
        drive(1'b1, 5'd5, 1'b1, 1'b0, 5'd0, 5'd0); tick();
        drive(1'b1, 5'd6, 1'b1, 1'b1, 5'd5, 5'd0); tick();
        chk("mid_pre_fwd", bus.fwd_sel, 4'b0001);
        drive(1'b1, 5'd7, 1'b1, 1'b0, 5'd6, 5'd0); #1;
        chk("mid_pre_stall", {3'b000, bus.load_use_stall}, 4'b0001);
        reset       = 1'b1;
        bus.advance = 1'b0;
        tick();
        chk("mid_reset_fwd", bus.fwd_sel, 4'b0000);
        chk("mid_reset_stall", {3'b000, bus.load_use_stall}, 4'b0000);
        reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
